// File: rtl/regfile_mp.sv
// regfile_mp -- multi-port integer register file.
//   NRD combinational read ports, NWR synchronous write ports, same-cycle
//   write-to-read bypass, optional hardwired-zero entry 0, and a post-reset
//   sweep that zeroes every entry before o_ready rises.
// Ports:
//   i_clk    rising-edge clock
//   i_rst    synchronous active-high reset (restarts the clear sweep)
//   i_we     [NWR]        per-port write enable
//   i_waddr  [NWR*AW]     packed write addresses, port k at [k*AW +: AW]
//   i_wdata  [NWR*XLEN]   packed write data, port k at [k*XLEN +: XLEN]
//   i_raddr  [NRD*AW]     packed read addresses
//   o_rdata  [NRD*XLEN]   packed combinational read data
//   o_ready  1 once the clear sweep has finished

// One read port: bypass mux over the write ports, then the stored entry.
module regfile_mp_rdport #(
  parameter int XLEN     = 32,
  parameter int DEPTH    = 32,
  parameter int AW       = 5,
  parameter int NWR      = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                        i_ready,
  input  logic [AW-1:0]               i_raddr,
  input  logic [NWR-1:0]              i_we,
  input  logic [NWR*AW-1:0]           i_waddr,
  input  logic [NWR*XLEN-1:0]         i_wdata,
  input  logic [DEPTH-1:0][XLEN-1:0]  i_mem,
  output logic [XLEN-1:0]             o_rdata
);
  always_comb begin
    o_rdata = '0;
    if (i_ready && !(ZERO_REG != 0 && i_raddr == '0)) begin
      o_rdata = i_mem[i_raddr];
      // Ascending scan: a higher-numbered port overrides, so port 1 wins.
      for (int k = 0; k < NWR; k++)
        if (i_we[k] && i_waddr[k*AW +: AW] == i_raddr)
          o_rdata = i_wdata[k*XLEN +: XLEN];
    end
  end
endmodule

module regfile_mp #(
  parameter int XLEN     = 32,
  parameter int DEPTH    = 32,
  parameter int AW       = $clog2(DEPTH),
  parameter int NRD      = 2,
  parameter int NWR      = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [NWR-1:0]       i_we,
  input  logic [NWR*AW-1:0]    i_waddr,
  input  logic [NWR*XLEN-1:0]  i_wdata,
  input  logic [NRD*AW-1:0]    i_raddr,
  output logic [NRD*XLEN-1:0]  o_rdata,
  output logic                 o_ready
);
  typedef enum logic {CLEAR = 1'b0, READY = 1'b1} state_t;

  localparam logic [AW-1:0] LAST = AW'(DEPTH-1);

  state_t                     r_state, w_next;
  logic [AW-1:0]              r_cnt;
  logic [DEPTH-1:0][XLEN-1:0] r_mem;

  always_comb begin
    w_next = r_state;
    if (i_rst)
      w_next = CLEAR;
    else if (r_state == CLEAR && r_cnt == LAST)
      w_next = READY;
  end

  always_ff @(posedge i_clk) begin
    r_state <= w_next;
    if (i_rst)
      r_cnt <= '0;
    else if (r_state == CLEAR)
      r_cnt <= r_cnt + 1'b1;  // wraps to 0 on the last entry; unused in READY
  end

  // Storage has no reset: the sweep defines every entry before o_ready.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      if (r_state == CLEAR) begin
        r_mem[r_cnt] <= '0;
      end else begin
        for (int k = 0; k < NWR; k++)
          if (i_we[k] && !(ZERO_REG != 0 && i_waddr[k*AW +: AW] == '0))
            r_mem[i_waddr[k*AW +: AW]] <= i_wdata[k*XLEN +: XLEN];
      end
    end
  end

  assign o_ready = (r_state == READY);

  for (genvar j = 0; j < NRD; j++) begin : g_rd
    regfile_mp_rdport #(
      .XLEN(XLEN), .DEPTH(DEPTH), .AW(AW), .NWR(NWR), .ZERO_REG(ZERO_REG)
    ) u_rd (
      .i_ready (o_ready),
      .i_raddr (i_raddr[j*AW +: AW]),
      .i_we    (i_we),
      .i_waddr (i_waddr),
      .i_wdata (i_wdata),
      .i_mem   (r_mem),
      .o_rdata (o_rdata[j*XLEN +: XLEN])
    );
  end
endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp. Two instances share clock and reset:
//   u_a: NRD=2, NWR=2, ZERO_REG=1 (main file, port conflict, zero entry)
//   u_b: NRD=1, NWR=1, ZERO_REG=0 (entry 0 behaves as an ordinary register)
module tb_regfile_mp;
  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  a_we;
  logic [9:0]  a_waddr;
  logic [63:0] a_wdata;
  logic [9:0]  a_raddr;
  logic [63:0] a_rdata;
  logic        a_ready;
  logic [0:0]  b_we;
  logic [4:0]  b_waddr;
  logic [31:0] b_wdata;
  logic [4:0]  b_raddr;
  logic [31:0] b_rdata;
  logic        b_ready;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  regfile_mp #(.XLEN(32), .DEPTH(32), .AW(5), .NRD(2), .NWR(2), .ZERO_REG(1)) u_a (
    .i_clk(clk), .i_rst(rst), .i_we(a_we), .i_waddr(a_waddr), .i_wdata(a_wdata),
    .i_raddr(a_raddr), .o_rdata(a_rdata), .o_ready(a_ready));

  regfile_mp #(.XLEN(32), .DEPTH(32), .AW(5), .NRD(1), .NWR(1), .ZERO_REG(0)) u_b (
    .i_clk(clk), .i_rst(rst), .i_we(b_we), .i_waddr(b_waddr), .i_wdata(b_wdata),
    .i_raddr(b_raddr), .o_rdata(b_rdata), .o_ready(b_ready));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    a_we = '0; a_waddr = '0; a_wdata = '0; a_raddr = '0;
    b_we = '0; b_waddr = '0; b_wdata = '0; b_raddr = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (3) tick();
    n_vec++;
    if (a_ready !== 1'b0 || b_ready !== 1'b0) begin
      n_err++; $display("FAIL reset_ready: got a=%b b=%b want 0", a_ready, b_ready);
    end
    n_vec++;
    if (a_rdata !== 64'h0 || b_rdata !== 32'h0) begin
      n_err++; $display("FAIL reset_rdata: got a=%h b=%h want 0", a_rdata, b_rdata);
    end
    rst = 1'b0;
    // ready must rise on exactly the 32nd edge after release.
    for (int i = 0; i < 32; i++) begin
      a_raddr = {5'(i), 5'(31 - i)};
      b_raddr = 5'(i);
      tick();
      n_vec++;
      if (a_ready !== (i == 31) || b_ready !== (i == 31)) begin
        n_err++;
        $display("FAIL sweep_ready edge %0d: got a=%b b=%b want %b", i + 1, a_ready, b_ready, (i == 31));
      end
      if (i != 31) begin
        n_vec++;
        if (a_rdata !== 64'h0 || b_rdata !== 32'h0) begin
          n_err++; $display("FAIL sweep_rdata edge %0d: got a=%h b=%h want 0", i + 1, a_rdata, b_rdata);
        end
      end
    end
    // Every entry holds 0 after the sweep.
    for (int i = 0; i < 32; i++) begin
      a_raddr = {5'(31 - i), 5'(i)};
      b_raddr = 5'(i);
      #1;
      n_vec++;
      if (a_rdata !== 64'h0 || b_rdata !== 32'h0) begin
        n_err++; $display("FAIL cleared_entry %0d: got a=%h b=%h want 0", i, a_rdata, b_rdata);
      end
    end
  endtask

  task automatic test_write_read();
    idle_inputs();
    a_we = 2'b01; a_waddr = {5'd0, 5'd5}; a_wdata = {32'h0, 32'h0000A61F};
    tick();
    idle_inputs();
    a_raddr = {5'd0, 5'd5};
    #1;
    n_vec++;
    if (a_rdata[31:0] !== 32'h0000A61F) begin
      n_err++; $display("FAIL write_read_5: got %h want 0000a61f", a_rdata[31:0]);
    end
    a_we = 2'b01; a_waddr = {5'd0, 5'd6}; a_wdata = {32'h0, 32'h00001F01};
    tick();
    idle_inputs();
    a_raddr = {5'd6, 5'd5};
    #1;
    n_vec++;
    if (a_rdata !== {32'h00001F01, 32'h0000A61F}) begin
      n_err++; $display("FAIL write_read_6: got %h want 00001f01_0000a61f", a_rdata);
    end
    b_we = 1'b1; b_waddr = 5'd17; b_wdata = 32'h12345678;
    tick();
    idle_inputs();
    b_raddr = 5'd17;
    #1;
    n_vec++;
    if (b_rdata !== 32'h12345678) begin
      n_err++; $display("FAIL write_read_b17: got %h want 12345678", b_rdata);
    end
  endtask

  task automatic test_bypass();
    idle_inputs();
    a_we = 2'b01; a_waddr = {5'd0, 5'd7}; a_wdata = {32'h0, 32'hDEADBEEF};
    a_raddr = {5'd5, 5'd7};
    #1;
    n_vec++;
    if (a_rdata !== {32'h0000A61F, 32'hDEADBEEF}) begin
      n_err++; $display("FAIL bypass_7: got %h want 0000a61f_deadbeef", a_rdata);
    end
    tick();
    a_we = '0;
    #1;
    n_vec++;
    if (a_rdata[31:0] !== 32'hDEADBEEF) begin
      n_err++; $display("FAIL bypass_stored_7: got %h want deadbeef", a_rdata[31:0]);
    end
  endtask

  task automatic test_zero_reg();
    idle_inputs();
    a_we = 2'b01; a_waddr = '0; a_wdata = {32'h0, 32'hFFFFFFFF}; a_raddr = '0;
    b_we = 1'b1;  b_waddr = '0; b_wdata = 32'hFFFFFFFF;          b_raddr = '0;
    #1;
    n_vec++;
    if (a_rdata[31:0] !== 32'h0) begin
      n_err++; $display("FAIL zero_bypass_a: got %h want 0", a_rdata[31:0]);
    end
    n_vec++;
    if (b_rdata !== 32'hFFFFFFFF) begin
      n_err++; $display("FAIL zero_bypass_b: got %h want ffffffff", b_rdata);
    end
    tick();
    a_we = '0; b_we = '0;
    #1;
    n_vec++;
    if (a_rdata[31:0] !== 32'h0) begin
      n_err++; $display("FAIL zero_stored_a: got %h want 0", a_rdata[31:0]);
    end
    n_vec++;
    if (b_rdata !== 32'hFFFFFFFF) begin
      n_err++; $display("FAIL zero_stored_b: got %h want ffffffff", b_rdata);
    end
  endtask

  task automatic test_conflict();
    idle_inputs();
    a_we = 2'b11; a_waddr = {5'd9, 5'd9}; a_wdata = {32'h00000022, 32'h00000011};
    a_raddr = {5'd9, 5'd9};
    #1;
    n_vec++;
    if (a_rdata !== {32'h22, 32'h22}) begin
      n_err++; $display("FAIL conflict_bypass: got %h want 22 on both", a_rdata);
    end
    tick();
    a_we = '0;
    #1;
    n_vec++;
    if (a_rdata !== {32'h22, 32'h22}) begin
      n_err++; $display("FAIL conflict_stored: got %h want 22 on both", a_rdata);
    end
    // Two distinct addresses in one cycle: both ports must land.
    a_we = 2'b11; a_waddr = {5'd11, 5'd10}; a_wdata = {32'h000000BB, 32'h000000AA};
    tick();
    a_we = '0; a_raddr = {5'd11, 5'd10};
    #1;
    n_vec++;
    if (a_rdata !== {32'hBB, 32'hAA}) begin
      n_err++; $display("FAIL dual_write: got %h want bb_aa", a_rdata);
    end
  endtask

  task automatic test_midsweep();
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (12) tick();  // sweep counter now at 12
    rst = 1'b1;
    tick();
    rst = 1'b0;
    // Writes issued throughout CLEAR must be dropped.
    a_we = 2'b01; a_waddr = {5'd0, 5'd20}; a_wdata = {32'h0, 32'h00000055};
    a_raddr = {5'd7, 5'd5};
    b_we = 1'b1; b_waddr = 5'd3; b_wdata = 32'h00000077; b_raddr = 5'd17;
    for (int i = 0; i < 32; i++) begin
      if (i == 31) begin
        a_we = '0; b_we = '0;
      end
      tick();
      n_vec++;
      if (a_ready !== (i == 31) || b_ready !== (i == 31)) begin
        n_err++;
        $display("FAIL midsweep_ready edge %0d: got a=%b b=%b want %b", i + 1, a_ready, b_ready, (i == 31));
      end
    end
    a_raddr = {5'd7, 5'd20};
    b_raddr = 5'd3;
    #1;
    n_vec++;
    if (a_rdata !== 64'h0) begin
      n_err++; $display("FAIL midsweep_lost_a: got %h want 0", a_rdata);
    end
    n_vec++;
    if (b_rdata !== 32'h0) begin
      n_err++; $display("FAIL midsweep_lost_b: got %h want 0", b_rdata);
    end
    b_raddr = 5'd17;
    #1;
    n_vec++;
    if (b_rdata !== 32'h0) begin
      n_err++; $display("FAIL midsweep_cleared_b17: got %h want 0", b_rdata);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_bypass();
    test_zero_reg();
    test_conflict();
    test_midsweep();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
